// File: rtl/mblock_initiator_pkg.sv
// mblock_initiator_pkg: selector codes, FSM states and request classification for the memory block bus.
// Rev 1.0
`default_nettype none

package mblock_initiator_pkg;

  localparam logic [1:0] SEL_ROM   = 2'b00;
  localparam logic [1:0] SEL_RAM   = 2'b01;
  localparam logic [1:0] SEL_IO    = 2'b10;
  localparam logic [1:0] SEL_CONST = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Only RAM is writable; the IO segment is reserved for both directions.
  function automatic logic req_is_error(input logic write, input logic [1:0] sel);
    return write ? (sel != SEL_RAM) : (sel == SEL_IO);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mblock_initiator_if.sv
// mblock_initiator_if: CPU request/response channel plus the memory block pins.
// Rev 1.0
`default_nettype none

interface mblock_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_sel;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  mem_selector;
  logic [15:0] mem_address;
  logic [31:0] mem_in;
  logic        mem_is_write;
  logic [31:0] mem_out;

  modport master (
    input  req_valid, req_write, req_sel, req_addr, req_wdata, mem_out,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_selector, mem_address, mem_in, mem_is_write
  );

  modport slave (
    output req_valid, req_write, req_sel, req_addr, req_wdata, mem_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_selector, mem_address, mem_in, mem_is_write
  );
endinterface

`default_nettype wire

// File: rtl/mblock_initiator_phase_timer.sv
// phase_timer: loadable down-counter; done is high while the count sits at 1.
// Rev 1.0
`default_nettype none

module phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so an idle timer never wraps back into a done state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/mblock_initiator.sv
// mblock_initiator: single-outstanding bus master sequencing setup -> strobe -> hold to the memory block.
// Rev 1.0
`default_nettype none

module mblock_initiator
  import mblock_initiator_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int WRITE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int READ_WAIT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  mblock_initiator_if.master  bus
);

  localparam int MAX_CYCLES = max_int(max_int(SETUP_CYCLES, WRITE_CYCLES),
                                      max_int(HOLD_CYCLES, READ_WAIT));
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  if ((SETUP_CYCLES < 1) || (WRITE_CYCLES < 1) || (HOLD_CYCLES < 1) || (READ_WAIT < 1)) begin : g_param_check
    $error("mblock_initiator: all timing parameters must be at least 1");
  end

  state_t           state;
  logic             write_q;
  logic             accept_err;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;

  assign accept_err = req_is_error(bus.req_write, bus.req_sel);

  // Every timed state is entered through a load, so done always refers to the current phase.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid && !accept_err) begin
          timer_load  = 1'b1;
          timer_value = CNT_W'(SETUP_CYCLES);
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = write_q ? CNT_W'(WRITE_CYCLES) : CNT_W'(READ_WAIT);
        end
      end
      ST_WRITE: begin
        if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = CNT_W'(HOLD_CYCLES);
        end
      end
      default: ;
    endcase
  end

  phase_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      write_q          <= 1'b0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_err      <= 1'b0;
      bus.rsp_data     <= '0;
      bus.mem_is_write <= 1'b0;
      bus.mem_selector <= SEL_CONST;
      bus.mem_address  <= '0;
      bus.mem_in       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            write_q       <= bus.req_write;
            if (accept_err) begin
              // Rejected requests never touch the memory pins.
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end else begin
              state            <= ST_SETUP;
              bus.mem_selector <= bus.req_sel;
              bus.mem_address  <= bus.req_addr;
              bus.mem_in       <= bus.req_wdata;
            end
          end
        end
        ST_SETUP: begin
          if (timer_done) begin
            if (write_q) begin
              state            <= ST_WRITE;
              bus.mem_is_write <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (timer_done) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= bus.mem_out;
          end
        end
        ST_WRITE: begin
          if (timer_done) begin
            state            <= ST_HOLD;
            bus.mem_is_write <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (timer_done) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mblock_initiator.sv
// tb_mblock_initiator: vector table, random traffic against a memory model, and timing corner sequences.
// Rev 1.0
`default_nettype none

module tb_mblock_initiator;
  import mblock_initiator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mblock_initiator_if bus ();
  mblock_initiator_if bus2 ();

  mblock_initiator dut (.clk(clk), .reset(reset), .bus(bus));

  mblock_initiator #(
    .SETUP_CYCLES (2),
    .WRITE_CYCLES (3),
    .HOLD_CYCLES  (2),
    .READ_WAIT    (2)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  function automatic int p_setup(input int inst); return (inst == 0) ? 1 : 2; endfunction
  function automatic int p_write(input int inst); return (inst == 0) ? 1 : 3; endfunction
  function automatic int p_hold (input int inst); return (inst == 0) ? 1 : 2; endfunction
  function automatic int p_rwait(input int inst); return (inst == 0) ? 1 : 2; endfunction

  function automatic logic [31:0] rom_word(input logic [15:0] a);   return {16'hC0DE, a}; endfunction
  function automatic logic [31:0] const_word(input logic [15:0] a); return {16'h5A5A, a ^ 16'hFFFF}; endfunction
  function automatic logic [31:0] ram_init(input logic [7:0] a);    return {24'h100000, a}; endfunction

  // Memory block model: 256-word RAM window, combinational read.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(8'(i));
    end else if (bus.mem_is_write && bus.mem_selector == SEL_RAM) begin
      ram[bus.mem_address[7:0]] <= bus.mem_in;
    end
  end
  assign bus.mem_out  = (bus.mem_selector == SEL_ROM)   ? rom_word(bus.mem_address) :
                        (bus.mem_selector == SEL_RAM)   ? ram[bus.mem_address[7:0]] :
                        (bus.mem_selector == SEL_CONST) ? const_word(bus.mem_address) : 32'h0;
  assign bus2.mem_out = rom_word(bus2.mem_address);

  // Reference view of RAM contents, updated only by legal writes.
  logic [31:0] ref_ram [0:255];

  function automatic logic [31:0] model_read(input logic [1:0] sel, input logic [15:0] a);
    case (sel)
      2'b00:   return rom_word(a);
      2'b01:   return ref_ram[a[7:0]];
      2'b11:   return const_word(a);
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic        rdy, rv, re, wr;
    logic [31:0] rd, din;
    logic [1:0]  sel;
    logic [15:0] addr;
  } snap_t;

  function automatic snap_t snap(input int inst);
    snap_t s;
    if (inst == 0) begin
      s.rdy = bus.req_ready;  s.rv = bus.rsp_valid;  s.re = bus.rsp_err;  s.wr = bus.mem_is_write;
      s.rd = bus.rsp_data;    s.din = bus.mem_in;    s.sel = bus.mem_selector; s.addr = bus.mem_address;
    end else begin
      s.rdy = bus2.req_ready; s.rv = bus2.rsp_valid; s.re = bus2.rsp_err; s.wr = bus2.mem_is_write;
      s.rd = bus2.rsp_data;   s.din = bus2.mem_in;   s.sel = bus2.mem_selector; s.addr = bus2.mem_address;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int inst, input logic v, input logic w, input logic [1:0] s,
                       input logic [15:0] a, input logic [31:0] d);
    if (inst == 0) begin
      bus.req_valid = v;  bus.req_write = w;  bus.req_sel = s;  bus.req_addr = a;  bus.req_wdata = d;
    end else begin
      bus2.req_valid = v; bus2.req_write = w; bus2.req_sel = s; bus2.req_addr = a; bus2.req_wdata = d;
    end
  endtask

  task automatic wait_ready(input int inst, input string tag);
    snap_t s;
    int    n;
    n = 0;
    s = snap(inst);
    while (!s.rdy && n < 20) begin
      @(negedge clk);
      n++;
      s = snap(inst);
    end
    chk({tag, " ready"}, 32'(s.rdy), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    snap_t s;
    s = snap(0);
    chk({tag, " req_ready"},    32'(s.rdy),  32'd1);
    chk({tag, " rsp_valid"},    32'(s.rv),   32'd0);
    chk({tag, " rsp_err"},      32'(s.re),   32'd0);
    chk({tag, " rsp_data"},     s.rd,        32'd0);
    chk({tag, " mem_is_write"}, 32'(s.wr),   32'd0);
    chk({tag, " mem_selector"}, 32'(s.sel),  32'd3);
    chk({tag, " mem_address"},  32'(s.addr), 32'd0);
    chk({tag, " mem_in"},       s.din,       32'd0);
  endtask

  // One complete transaction; returns the cycle (relative to the accept edge) of the response pulse.
  task automatic run_req(input int inst, input logic wr, input logic [1:0] sel, input logic [15:0] addr,
                         input logic [31:0] wd, input string tag,
                         output int lat, output logic err, output logic [31:0] data);
    snap_t s, pre;
    logic  exp_err, stable, got;
    int    wcnt, first_w;
    exp_err = wr ? (sel != 2'b01) : (sel == 2'b10);
    wait_ready(inst, tag);
    pre = snap(inst);
    drive(inst, 1'b1, wr, sel, addr, wd);
    @(negedge clk);
    drive(inst, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    wcnt = 0; first_w = -1; stable = 1'b1; got = 1'b0; lat = -1; err = 1'b0; data = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      s = snap(inst);
      if (s.wr) begin
        wcnt++;
        if (first_w < 0) first_w = k;
      end
      if (exp_err) begin
        if (s.sel !== pre.sel || s.addr !== pre.addr || s.din !== pre.din) stable = 1'b0;
      end else if (s.sel !== sel || s.addr !== addr || s.din !== wd) begin
        stable = 1'b0;
      end
      if (s.rv) begin
        got = 1'b1; lat = k; err = s.re; data = s.rd;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " rsp_seen"}, 32'(got), 32'd1);
    chk({tag, " strobe_cycles"}, 32'(wcnt), (exp_err || !wr) ? 32'd0 : 32'(p_write(inst)));
    if (!exp_err && wr) chk({tag, " strobe_start"}, 32'(first_w), 32'(1 + p_setup(inst)));
    chk({tag, " mem_stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    s = snap(inst);
    chk({tag, " pulse_end"},  32'(s.rv),  32'd0);
    chk({tag, " ready_back"}, 32'(s.rdy), 32'd1);
    if (inst == 0 && wr && !exp_err) ref_ram[addr[7:0]] = wd;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 11;
  vec_t        vecs [NV];
  int          lat, acc1, rsp1, acc2, rsp2, e_lat;
  logic        err, e_err, wr, bb_ok, seen;
  logic [1:0]  sel;
  logic [15:0] addr;
  logic [31:0] data, wd, e_data, d1, d2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, SEL_ROM,   16'h0004, 32'h0,        1'b0, 3, 32'hC0DE0004};
    vecs[1]  = '{1'b1, SEL_RAM,   16'h0010, 32'hDEADBEEF, 1'b0, 4, 32'h0};
    vecs[2]  = '{1'b0, SEL_RAM,   16'h0010, 32'h0,        1'b0, 3, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, SEL_CONST, 16'h0020, 32'h12345678, 1'b1, 1, 32'h0};
    vecs[4]  = '{1'b0, SEL_RAM,   16'h0020, 32'h0,        1'b0, 3, 32'h10000020};
    vecs[5]  = '{1'b1, SEL_ROM,   16'h0005, 32'h55555555, 1'b1, 1, 32'h0};
    vecs[6]  = '{1'b1, SEL_IO,    16'h0006, 32'h66666666, 1'b1, 1, 32'h0};
    vecs[7]  = '{1'b0, SEL_IO,    16'h0007, 32'h0,        1'b1, 1, 32'h0};
    vecs[8]  = '{1'b0, SEL_CONST, 16'h0008, 32'h0,        1'b0, 3, 32'h5A5AFFF7};
    vecs[9]  = '{1'b1, SEL_RAM,   16'h0020, 32'hCAFEF00D, 1'b0, 4, 32'h0};
    vecs[10] = '{1'b0, SEL_RAM,   16'h0020, 32'h0,        1'b0, 3, 32'hCAFEF00D};
    for (int i = 0; i < 256; i++) ref_ram[i] = ram_init(8'(i));

    reset = 1'b1;
    mem_init = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_req(0, vecs[i].wr, vecs[i].sel, vecs[i].addr, vecs[i].wd, $sformatf("vec%0d", i), lat, err, data);
      chk($sformatf("vec%0d latency", i),  32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d rsp_err", i),  32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d rsp_data", i), data,     vecs[i].exp_data);
    end

    for (int i = 0; i < 40; i++) begin
      wr     = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      addr   = 16'($urandom_range(0, 15));
      wd     = $urandom;
      e_err  = wr ? (sel != 2'b01) : (sel == 2'b10);
      e_lat  = e_err ? 1 : (wr ? 1 + p_setup(0) + p_write(0) + p_hold(0) : 1 + p_setup(0) + p_rwait(0));
      e_data = (e_err || wr) ? 32'h0 : model_read(sel, addr);
      run_req(0, wr, sel, addr, wd, $sformatf("rnd%0d", i), lat, err, data);
      chk($sformatf("rnd%0d latency", i),  32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d rsp_err", i),  32'(err), 32'(e_err));
      chk($sformatf("rnd%0d rsp_data", i), data,     e_data);
    end

    // Reset landing on the strobe cycle aborts the write with no response.
    wait_ready(0, "rst_mid");
    drive(0, 1'b1, 1'b1, SEL_RAM, 16'h0030, 32'hA5A5A5A5);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    @(negedge clk);
    chk("rst_mid strobe_before", 32'(bus.mem_is_write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rst_mid");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst_mid no_rsp", 32'(seen), 32'd0);

    run_req(1, 1'b1, SEL_RAM, 16'h0040, 32'h11223344, "stretch_wr", lat, err, data);
    chk("stretch_wr latency", 32'(lat), 32'd8);
    chk("stretch_wr rsp_err", 32'(err), 32'd0);
    run_req(1, 1'b0, SEL_ROM, 16'h0009, 32'h0, "stretch_rd", lat, err, data);
    chk("stretch_rd latency", 32'(lat), 32'd5);
    chk("stretch_rd rsp_data", data, 32'hC0DE0009);
    run_req(1, 1'b1, SEL_ROM, 16'h0009, 32'h0, "stretch_err", lat, err, data);
    chk("stretch_err latency", 32'(lat), 32'd1);
    chk("stretch_err rsp_err", 32'(err), 32'd1);

    // Back-to-back reads with req_valid held high and request fields scrambled while busy.
    wait_ready(0, "b2b");
    drive(0, 1'b1, 1'b0, SEL_ROM, 16'h0001, 32'h0);
    acc1 = 0; rsp1 = -1; acc2 = -1; rsp2 = -1; bb_ok = 1'b1; d1 = 32'h0; d2 = 32'h0;
    for (int c = 1; c < 40 && acc2 < 0; c++) begin
      @(negedge clk);
      if (rsp1 < 0) begin
        if (bus.mem_address !== 16'h0001) bb_ok = 1'b0;
        if (bus.rsp_valid) begin
          rsp1 = c;
          d1 = bus.rsp_data;
          drive(0, 1'b1, 1'b0, SEL_ROM, 16'h0002, 32'h0);
        end else begin
          drive(0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), $urandom);
        end
      end else if (bus.req_ready) begin
        acc2 = c;
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    chk("b2b second_address", 32'(bus.mem_address), 32'h0002);
    for (int c = acc2 + 1; c < acc2 + 40; c++) begin
      if (bus.rsp_valid) begin
        rsp2 = c;
        d2 = bus.rsp_data;
        break;
      end
      @(negedge clk);
    end
    chk("b2b first_latency",  32'(rsp1 - acc1), 32'd3);
    chk("b2b accept_spacing", 32'(acc2 - rsp1), 32'd1);
    chk("b2b second_latency", 32'(rsp2 - acc2), 32'd3);
    chk("b2b first_data",     d1, 32'hC0DE0001);
    chk("b2b second_data",    d2, 32'hC0DE0002);
    chk("b2b busy_hold",      32'(bb_ok), 32'd1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mblock_initiator.md
Name: mblock_initiator

Overview:
- Sequential bus master for the memory block: accepts one request at a time from the CPU side and drives selector/address/in/is_write.
- Sequences every access as setup -> strobe -> hold, so is_write is never asserted while address, selector or data are changing.
- Returns read data and an error flag on a one-cycle response pulse.
- Sits between the CPU control unit and the memory block. It is the only driver of the memory block's inputs.

Parameters:
- SETUP_CYCLES, 1, cycles the address, selector and data are held stable before a strobe or sample; minimum 1.
- WRITE_CYCLES, 1, cycles is_write stays high; minimum 1.
- HOLD_CYCLES, 1, cycles the address and data are held after is_write falls; minimum 1.
- READ_WAIT, 1, cycles after setup before mem_out is sampled; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_sel  in  2  segment: 00 ROM, 01 RAM, 10 IO (reserved), 11 CONST.
- req_addr  in  16  word address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  request rejected; qualified by rsp_valid.
- mem_selector  out  2  to the memory block selector.
- mem_address  out  16  to the memory block address.
- mem_in  out  32  to the memory block write data.
- mem_is_write  out  1  write strobe, registered.
- mem_out  in  32  read data from the memory block.

Behaviour:
- Reset, sampled on a clk edge with reset=1:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
  - mem_is_write=0, mem_selector=2'b11, mem_address=0, mem_in=0.
- All outputs are registered.
- States: IDLE, SETUP, READ, WRITE, HOLD, RESP.
- A phase counter is loaded on every state entry and decrements; the state advances when the counter reaches 1.
- Accept: req_valid & req_ready at edge T latches the request.
- Error classification at accept:
  - Write to any selector other than 01 is an error.
  - Read with selector 10 is an error.
  - Error path: next state RESP at T+1 with rsp_err=1 and rsp_data=0. The mem_* outputs are unchanged and no strobe is issued.
- Legal request:
  - At edge T, mem_selector, mem_address and mem_in load from the request; state becomes SETUP for SETUP_CYCLES.
  - These mem_* outputs change only at this accept edge and are otherwise held, including while idle.
- Read path: SETUP -> READ for READ_WAIT cycles.
  - mem_out is captured into rsp_data at the last READ edge.
  - Then RESP.
  - Default latency: accept at T, rsp_valid at T+3.
- Write path: SETUP -> WRITE -> HOLD -> RESP.
  - mem_is_write rises entering WRITE and falls entering HOLD.
  - Default latency: accept at T, mem_is_write high during T+2 only, rsp_valid at T+4.
- RESP:
  - Lasts exactly one cycle with rsp_valid=1, then IDLE.
  - req_ready=0 in RESP, so back-to-back accepts are spaced by at least one idle-ready cycle.
- req_* inputs are ignored while req_ready=0.
- Reset mid-transaction:
  - Next edge forces IDLE and reset values, and mem_is_write=0 immediately at that edge.
  - No rsp_valid is produced for the aborted request.
- A parameter below 1 is illegal and must stop elaboration.
- The counter width must hold the maximum parameter value; wrap-around is not allowed.

Decomposition:
- Shared include/package holds:
  - SEL_ROM=2'b00, SEL_RAM=2'b01, SEL_IO=2'b10, SEL_CONST=2'b11.
  - State encodings.
  - The error-classification rule as a function/macro, reused by the CPU decoder.
- One sub-module, phase_timer: loadable down-counter with a done flag, used for all timed states.

Test Plan:
- Read ROM: req sel=00 addr=0x0004 at T -> mem_address=0x0004 from T+1; rsp_valid at T+3 with rsp_data equal to the ROM word at address 4; rsp_err=0; mem_is_write never 1.
- Write then read RAM: write sel=01 addr=0x0010 data=0xDEADBEEF -> mem_is_write high exactly one cycle with address and data stable from T+1 through T+3; rsp_valid at T+4; a following read of 0x0010 returns 0xDEADBEEF.
- Illegal write: write sel=11 addr=0x0020 -> rsp_valid at T+1 with rsp_err=1 and rsp_data=0; mem_* unchanged; RAM contents unchanged (confirm by reading back).
- Reset mid-write: assert reset during the WRITE cycle -> mem_is_write=0 at the next edge; no rsp_valid; req_ready=1; all outputs at reset values.
- Stretched timing (SETUP=2, WRITE=3, HOLD=2): write -> is_write high for exactly 3 cycles, with 2 stable cycles before and 2 after; rsp_valid at T+8.
- Back-to-back: req_valid held high with two reads -> second accept no earlier than the cycle after the first RESP; req_* changes while busy have no effect on mem_*.
